// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage 16-bit pipeline: arbitrates memory waits,
// load-use stalls, branch redirects and fetch misses, and sequences the HLT drain.
module pipeline_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             forward_stall,
    input  logic             branch_taken_ex,
    input  logic             imem_ready,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             halt_id,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             if_id_flush,
    output logic             id_ex_we,
    output logic             id_ex_flush,
    output logic             ex_mem_we,
    output logic             ex_mem_bubble,
    output logic             mem_wb_we,
    output logic             mem_wb_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count
);

    localparam int DCW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t           state_r;
    state_t           stateNext_s;
    logic [DCW-1:0]   drainCnt_r;
    logic [DCW-1:0]   drainCntNext_s;
    logic             halted_r;
    logic [CNT_W-1:0] stallCnt_r;

    logic memWait_s;
    logic pcWe_s, ifIdWe_s, ifIdFlush_s, idExWe_s, idExFlush_s;
    logic exMemWe_s, exMemBubble_s, memWbWe_s, memWbBubble_s;

    assign memWait_s = dmem_req & ~dmem_ready;

    // Next-state and per-stage enable/flush decode, highest-priority hazard first
    always_comb begin
        stateNext_s    = state_r;
        drainCntNext_s = drainCnt_r;
        pcWe_s         = 1'b0;
        ifIdWe_s       = 1'b0;
        ifIdFlush_s    = 1'b0;
        idExWe_s       = 1'b0;
        idExFlush_s    = 1'b0;
        exMemWe_s      = 1'b0;
        exMemBubble_s  = 1'b0;
        memWbWe_s      = 1'b0;
        memWbBubble_s  = 1'b0;
        case (state_r)
            RUN, DRAIN: begin
                if (memWait_s) begin
                    // Whole pipe frozen; MEM/WB takes a NOP so WB does not repeat a write
                    memWbWe_s     = 1'b1;
                    memWbBubble_s = 1'b1;
                end else if (forward_stall) begin
                    exMemWe_s     = 1'b1;
                    exMemBubble_s = 1'b1;
                    memWbWe_s     = 1'b1;
                end else begin
                    ifIdWe_s  = 1'b1;
                    idExWe_s  = 1'b1;
                    exMemWe_s = 1'b1;
                    memWbWe_s = 1'b1;
                    if (state_r == DRAIN) begin
                        ifIdFlush_s = 1'b1;
                        if (drainCnt_r <= DCW'(1)) begin
                            stateNext_s    = HALTED;
                            drainCntNext_s = '0;
                        end else begin
                            drainCntNext_s = drainCnt_r - DCW'(1);
                        end
                    end else if (branch_taken_ex) begin
                        pcWe_s      = 1'b1;
                        ifIdFlush_s = 1'b1;
                        idExFlush_s = 1'b1;
                    end else if (halt_id) begin
                        // HLT moves on to ID/EX; the younger fetch behind it is discarded
                        ifIdFlush_s    = 1'b1;
                        stateNext_s    = DRAIN;
                        drainCntNext_s = DCW'(DRAIN_CYCLES);
                    end else if (!imem_ready) begin
                        ifIdFlush_s = 1'b1;
                    end else begin
                        pcWe_s = 1'b1;
                    end
                end
            end
            HALTED: begin
                stateNext_s = HALTED;
            end
            default: begin
                stateNext_s    = RUN;
                drainCntNext_s = '0;
            end
        endcase
    end

    // State, drain counter, halted flag and saturating stall counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= RUN;
            drainCnt_r <= '0;
            halted_r   <= 1'b0;
            stallCnt_r <= '0;
        end else begin
            state_r    <= stateNext_s;
            drainCnt_r <= drainCntNext_s;
            halted_r   <= (stateNext_s == HALTED);
            if ((state_r != HALTED) && !idExWe_s && (stallCnt_r != {CNT_W{1'b1}})) begin
                stallCnt_r <= stallCnt_r + CNT_W'(1);
            end else begin
                stallCnt_r <= stallCnt_r;
            end
        end
    end

    // Controls are forced inactive while reset is held
    assign pc_we         = rst_n & pcWe_s;
    assign if_id_we      = rst_n & ifIdWe_s;
    assign if_id_flush   = rst_n & ifIdFlush_s;
    assign id_ex_we      = rst_n & idExWe_s;
    assign id_ex_flush   = rst_n & idExFlush_s;
    assign ex_mem_we     = rst_n & exMemWe_s;
    assign ex_mem_bubble = rst_n & exMemBubble_s;
    assign mem_wb_we     = rst_n & memWbWe_s;
    assign mem_wb_bubble = rst_n & memWbBubble_s;
    assign halted        = halted_r;
    assign stall_count   = stallCnt_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus random traffic against a
// rule-table reference model of the hazard priorities and halt drain.
module tb_pipeline_hazard_ctrl;

    localparam int DC   = 3;
    localparam int CW   = 4;
    localparam int SATV = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic fs = 1'b0, br = 1'b0, imr = 1'b1, dreq = 1'b0, drdy = 1'b0, hlt = 1'b0;
    logic pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush;
    logic ex_mem_we, ex_mem_bubble, mem_wb_we, mem_wb_bubble, halted;
    logic [CW-1:0] stall_count;

    pipeline_hazard_ctrl #(.DRAIN_CYCLES(DC), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .forward_stall(fs), .branch_taken_ex(br),
        .imem_ready(imr), .dmem_req(dreq), .dmem_ready(drdy), .halt_id(hlt),
        .pc_we(pc_we), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
        .id_ex_we(id_ex_we), .id_ex_flush(id_ex_flush), .ex_mem_we(ex_mem_we),
        .ex_mem_bubble(ex_mem_bubble), .mem_wb_we(mem_wb_we), .mem_wb_bubble(mem_wb_bubble),
        .halted(halted), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    // Reference model: mode 0=running, 1=draining, 2=halted
    int mode = 0;
    int left = 0;
    int stalls = 0;

    // {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, ex_mem_bubble, mem_wb_we, mem_wb_bubble}
    wire [8:0] outs = {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush,
                       ex_mem_we, ex_mem_bubble, mem_wb_we, mem_wb_bubble};

    localparam logic [8:0] P_FREEZE = 9'b000000011;
    localparam logic [8:0] P_LDUSE  = 9'b000001110;
    localparam logic [8:0] P_REDIR  = 9'b111111010;
    localparam logic [8:0] P_NOFET  = 9'b011101010;
    localparam logic [8:0] P_NORM   = 9'b110101010;

    function automatic logic [8:0] model_out();
        if (!rst_n || mode == 2) return 9'b0;
        if (dreq && !drdy) return P_FREEZE;
        if (fs) return P_LDUSE;
        if (mode == 1) return P_NOFET;
        if (br) return P_REDIR;
        if (hlt || !imr) return P_NOFET;
        return P_NORM;
    endfunction

    task automatic tick();
        logic [8:0] e;
        logic adv;
        e = model_out();
        adv = !(dreq && !drdy) && !fs;
        @(posedge clk);
        if (!rst_n) begin
            mode = 0; left = 0; stalls = 0;
        end else begin
            if (mode != 2 && !e[5] && stalls < SATV) stalls++;
            if (mode == 0 && adv && !br && hlt) begin
                mode = 1; left = DC;
            end else if (mode == 1 && adv) begin
                if (left <= 1) mode = 2;
                else left--;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        {fs, br, imr, dreq, drdy, hlt} = 6'b001000;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mode = 0; left = 0; stalls = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        {fs, br, imr, dreq, drdy, hlt} = 6'b011001;
        #3;
        total++;
        if (outs !== 9'b0) begin bad++; $display("FAIL reset_ctrl got=%b exp=%b", outs, 9'b0); end
        total++;
        if ({halted, stall_count} !== {1'b0, {CW{1'b0}}}) begin
            bad++; $display("FAIL reset_regs got=%b/%0d exp=0/0", halted, stall_count);
        end
        do_reset();
    endtask

    task automatic test_load_use();
        logic [5:0] seq [2] = '{6'b101000, 6'b001000};
        do_reset();
        for (int i = 0; i < 2; i++) begin
            {fs, br, imr, dreq, drdy, hlt} = seq[i];
            @(negedge clk);
            total++;
            if (outs !== model_out() || outs !== ((i == 0) ? P_LDUSE : P_NORM)) begin
                bad++; $display("FAIL load_use step=%0d got=%b exp=%b", i, outs, model_out());
            end
            total++;
            if (stall_count !== CW'(i)) begin
                bad++; $display("FAIL load_use_cnt step=%0d got=%0d exp=%0d", i, stall_count, i);
            end
            tick();
        end
    endtask

    task automatic test_branch_vs_stall();
        logic [5:0] seq [3] = '{6'b111000, 6'b011000, 6'b001000};
        logic [8:0] fix [3] = '{P_LDUSE, P_REDIR, P_NORM};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            {fs, br, imr, dreq, drdy, hlt} = seq[i];
            @(negedge clk);
            total++;
            if (outs !== model_out() || outs !== fix[i]) begin
                bad++; $display("FAIL branch_vs_stall step=%0d got=%b exp=%b", i, outs, fix[i]);
            end
            tick();
        end
    endtask

    task automatic test_data_miss();
        logic [5:0] seq [6] = '{6'b101100, 6'b101100, 6'b101100, 6'b101100, 6'b001110, 6'b001000};
        logic [8:0] fix [6] = '{P_FREEZE, P_FREEZE, P_FREEZE, P_FREEZE, P_NORM, P_NORM};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            {fs, br, imr, dreq, drdy, hlt} = seq[i];
            @(negedge clk);
            total++;
            if (outs !== model_out() || outs !== fix[i]) begin
                bad++; $display("FAIL data_miss step=%0d got=%b exp=%b", i, outs, fix[i]);
            end
            total++;
            if (stall_count !== CW'((i < 4) ? i : 4)) begin
                bad++; $display("FAIL data_miss_cnt step=%0d got=%0d exp=%0d", i, stall_count, (i < 4) ? i : 4);
            end
            tick();
        end
    endtask

    task automatic test_halt();
        logic [5:0] seq [8] = '{6'b001001, 6'b001000, 6'b001100, 6'b001000,
                                6'b001000, 6'b001000, 6'b101001, 6'b011000};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            {fs, br, imr, dreq, drdy, hlt} = seq[i];
            @(negedge clk);
            total++;
            if (outs !== model_out() || pc_we !== 1'b0 || (i >= 5 && outs !== 9'b0)) begin
                bad++; $display("FAIL halt_ctrl step=%0d got=%b exp=%b", i, outs, model_out());
            end
            total++;
            if (halted !== (i >= 5) || stall_count !== CW'(stalls)) begin
                bad++; $display("FAIL halt_flag step=%0d got=%b/%0d exp=%b/%0d", i, halted, stall_count, i >= 5, stalls);
            end
            tick();
        end
    endtask

    task automatic test_halt_squash();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            {fs, br, imr, dreq, drdy, hlt} = (i == 0) ? 6'b011001 : 6'b001000;
            @(negedge clk);
            total++;
            if (outs !== model_out() || outs !== ((i == 0) ? P_REDIR : P_NORM) || halted !== 1'b0) begin
                bad++; $display("FAIL halt_squash step=%0d got=%b/%b exp=%b/0", i, outs, halted, model_out());
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        logic [5:0] seq [3] = '{6'b101000, 6'b001001, 6'b001000};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            {fs, br, imr, dreq, drdy, hlt} = seq[i];
            @(negedge clk);
            total++;
            if (outs !== model_out()) begin
                bad++; $display("FAIL pre_reset step=%0d got=%b exp=%b", i, outs, model_out());
            end
            tick();
        end
        total++;
        if (stall_count !== CW'(1) || mode != 1) begin
            bad++; $display("FAIL pre_reset_cnt got=%0d exp=1", stall_count);
        end
        #1 rst_n = 1'b0;
        #1;
        mode = 0; left = 0; stalls = 0;
        total++;
        if ({halted, stall_count, outs} !== {1'b0, {CW{1'b0}}, 9'b0}) begin
            bad++; $display("FAIL async_reset got=%b/%0d/%b exp=0/0/0", halted, stall_count, outs);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            {fs, br, imr, dreq, drdy, hlt} = 6'b001000;
            @(negedge clk);
            total++;
            if (outs !== P_NORM || halted !== 1'b0) begin
                bad++; $display("FAIL post_reset step=%0d got=%b/%b exp=%b/0", i, outs, halted, P_NORM);
            end
            tick();
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < SATV + 5; i++) begin
            {fs, br, imr, dreq, drdy, hlt} = 6'b101000;
            @(negedge clk);
            total++;
            if (stall_count !== CW'(stalls) || outs !== P_LDUSE) begin
                bad++; $display("FAIL saturate step=%0d got=%0d exp=%0d", i, stall_count, stalls);
            end
            tick();
        end
        total++;
        if (stall_count !== CW'(SATV)) begin
            bad++; $display("FAIL saturate_end got=%0d exp=%0d", stall_count, SATV);
        end
    endtask

    task automatic test_random();
        int haltedFor;
        haltedFor = 0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ((i % 250) == 249 || haltedFor > 6) begin
                do_reset();
                haltedFor = 0;
            end
            fs   = ($urandom_range(4, 0) == 0);
            br   = ($urandom_range(5, 0) == 0);
            imr  = ($urandom_range(4, 0) != 0);
            dreq = ($urandom_range(2, 0) == 0);
            drdy = ($urandom_range(1, 0) == 0);
            hlt  = ($urandom_range(9, 0) == 0);
            @(negedge clk);
            total++;
            if (outs !== model_out()) begin
                bad++; $display("FAIL random_ctrl cyc=%0d in=%b got=%b exp=%b", i, {fs, br, imr, dreq, drdy, hlt}, outs, model_out());
            end
            total++;
            if (halted !== (mode == 2) || stall_count !== CW'(stalls)) begin
                bad++; $display("FAIL random_regs cyc=%0d got=%b/%0d exp=%b/%0d", i, halted, stall_count, mode == 2, stalls);
            end
            if (mode == 2) haltedFor++;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_vs_stall();
        test_data_miss();
        test_halt();
        test_halt_squash();
        test_async_reset();
        test_saturate();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage 16-bit pipeline.
- Consumes the load-use stall from the EX-stage forwarding unit, the EX-resolved branch redirect, instruction/data memory ready handshakes and the decoded HLT.
- Drives write-enables and bubble/flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Sequences the halt drain and keeps a saturating stall-cycle counter.

Parameters:
- DRAIN_CYCLES, 3: cycles after HLT leaves ID until the youngest older instruction has written back.
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- forward_stall  in  1  load-use hazard from the EX-stage forwarding unit.
- branch_taken_ex  in  1  branch/jump in EX redirects the PC.
- imem_ready  in  1  fetch data valid this cycle.
- dmem_req  in  1  MEM stage holds a load or store.
- dmem_ready  in  1  data memory completes the MEM-stage access this cycle.
- halt_id  in  1  HLT decoded in ID.
- pc_we  out  1  PC register update enable.
- if_id_we  out  1  IF/ID load enable.
- if_id_flush  out  1  IF/ID loads a NOP.
- id_ex_we  out  1  ID/EX load enable.
- id_ex_flush  out  1  ID/EX loads a NOP.
- ex_mem_we  out  1  EX/MEM load enable.
- ex_mem_bubble  out  1  EX/MEM loads a NOP.
- mem_wb_we  out  1  MEM/WB load enable.
- mem_wb_bubble  out  1  MEM/WB loads a NOP.
- halted  out  1  pipeline fully drained after HLT.
- stall_count  out  CNT_W  saturating count of cycles with id_ex_we=0 while RUN or DRAIN.

Behaviour:
- States: RUN, DRAIN, HALTED. Registered state, drain counter (clog2(DRAIN_CYCLES+1) bits), halted, stall_count.
- Outputs other than halted and stall_count are combinational from state and inputs.
- Reset (async, rst_n=0): state=RUN, counter=0, halted=0, stall_count=0.
- During reset, all *_we outputs = 0 and all flush/bubble outputs = 0.
- memwait = dmem_req & ~dmem_ready.
- Priority in RUN, highest first:
  1. memwait: all *_we=0 except mem_wb_we=1 with mem_wb_bubble=1. Nothing else advances. forward_stall, branch_taken_ex and halt_id are ignored this cycle.
  2. forward_stall: pc_we=0, if_id_we=0, id_ex_we=0; ex_mem_we=1 with ex_mem_bubble=1; mem_wb_we=1. The load advances to MEM/WB and the consumer re-executes next cycle with the forwarded value. branch_taken_ex is ignored because the branch operand is not yet valid.
  3. branch_taken_ex: pc_we=1 (redirect), if_id_flush=1, id_ex_flush=1, all *_we=1. halt_id is squashed (the HLT is on the wrong path) and the state stays RUN. Redirect wins over ~imem_ready.
  4. ~imem_ready: pc_we=0, if_id_we=1 with if_id_flush=1, downstream *_we=1.
  5. Otherwise all *_we=1 and no flush/bubble.
- halt_id in RUN with cases 1–3 inactive (imem_ready irrelevant):
  - Next state DRAIN, counter loads DRAIN_CYCLES.
  - This cycle: pc_we=0, HLT enters ID/EX normally.
- DRAIN:
  - pc_we=0, if_id_flush=1; ID/EX, EX/MEM and MEM/WB advance as in RUN.
  - memwait still freezes the pipeline and the counter.
  - forward_stall still bubbles EX/MEM and does not decrement the counter.
  - Counter decrements once per advancing cycle. When it reaches 0: next state HALTED, halted=1.
  - branch_taken_ex and halt_id are ignored.
- HALTED: all *_we=0, flush/bubble=0, halted=1. Leaves only via reset.
- stall_count: increments when state is RUN or DRAIN and id_ex_we=0. Saturates at 2^CNT_W-1 with no wrap.
- Reset mid-DRAIN or mid-memwait returns immediately to RUN with counters cleared.

Test Plan:
1. Load-use: forward_stall=1 for 1 cycle, other inputs idle → pc_we=if_id_we=id_ex_we=0, ex_mem_bubble=1, mem_wb_we=1; next cycle all we=1; stall_count=1.
2. Branch vs stall: forward_stall=1 and branch_taken_ex=1 same cycle → stall response, no flush; next cycle branch_taken_ex=1 alone → pc_we=1, if_id_flush=id_ex_flush=1.
3. Data miss: dmem_req=1, dmem_ready=0 for 4 cycles with forward_stall=1 → only mem_wb_we=1 and mem_wb_bubble=1 for 4 cycles; stall_count=4; normal flow resumes when dmem_ready=1.
4. Halt: halt_id=1 single cycle, DRAIN_CYCLES=3, one memwait cycle injected mid-drain → halted=1 exactly 5 cycles after halt_id; pc_we=0 throughout; then all we=0.
5. Halt squash: halt_id=1 with branch_taken_ex=1 → state stays RUN, halted never asserts, pc_we=1.
6. Reset: assert rst_n=0 mid-DRAIN (asynchronously, between edges) → halted=0 and stall_count=0 immediately; after release the controller is in RUN with all we=1 on idle inputs.
